i2cm_s2p_buf: RTL

I2CM_S2P_BUF -- requirements
Module: i2cm_s2p_buf

---
 rtl/i2cm_s2p_buf.sv | 99 +++++++++
 1 files changed

// File: rtl/i2cm_s2p_buf.sv
// rtl/i2cm_s2p_buf.sv - serial-to-parallel word assembler with single-entry holding register
module i2cm_s2p_buf #(
    parameter int DW        = 8,
    parameter int LSB_FIRST = 0,
    localparam int CW       = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_shift_en,
    input  logic          i_data_ser,
    input  logic          i_clr,
    input  logic          i_rd_ack,
    input  logic          i_ovr_clr,
    output logic [DW-1:0] o_data_par,
    output logic          o_data_vld,
    output logic [CW-1:0] o_bit_cnt,
    output logic          o_busy,
    output logic          o_ovr
);

    typedef enum logic {IDLE, RCV} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   sr_q, sr_d, sr_shift;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   par_q;
    logic            vld_q, ovr_q, busy_q;
    logic            complete, accept, overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == RCV);
        end
    end

    // i_clr outranks i_shift_en, so an aborted cycle can never complete a word.
    always_comb begin
        sr_shift = (LSB_FIRST != 0) ? {i_data_ser, sr_q[DW-1:1]}
                                    : {sr_q[DW-2:0], i_data_ser};
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        complete = 1'b0;
        if (i_clr) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (i_shift_en) begin
            sr_d = sr_shift;
            if (cnt_q == CW'(DW - 1)) begin
                cnt_d    = '0;
                state_d  = IDLE;
                complete = 1'b1;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                state_d = RCV;
            end
        end
    end

    // A pop in the completing cycle frees the slot, so the new word is taken instead of dropped.
    assign accept  = complete && (!vld_q || i_rd_ack);
    assign overrun = complete && vld_q && !i_rd_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (accept) begin
                par_q <= sr_shift;
                vld_q <= 1'b1;
            end else if (i_rd_ack) begin
                vld_q <= 1'b0;
            end
            if (overrun) begin
                ovr_q <= 1'b1;
            end else if (i_ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign o_data_par = par_q;
    assign o_data_vld = vld_q;
    assign o_bit_cnt  = cnt_q;
    assign o_busy     = busy_q;
    assign o_ovr      = ovr_q;

endmodule
